// File: rtl/receptor_pcs.sv
// rtl/receptor_pcs.sv - 1000BASE-X PCS receive ordered-set state machine
module receptor_pcs (
    input  logic       GTX_CLK,
    input  logic       RESET,
    input  logic [7:0] rx_code_group,
    input  logic       rx_is_k,
    input  logic       sync_status,
    output logic [7:0] RXD,
    output logic       RX_DV,
    output logic       RX_ER,
    output logic       receiving,
    output logic       rx_even,
    output logic [7:0] pkt_count
);
    localparam logic [7:0] K_COMMA  = 8'hBC;
    localparam logic [7:0] K_SOP    = 8'hFB;
    localparam logic [7:0] K_EOP    = 8'hFD;
    localparam logic [7:0] K_CEXT   = 8'hF7;
    localparam logic [7:0] PREAMBLE = 8'h55;

    typedef enum logic [2:0] {
        LINK_FAILED, WAIT_FOR_K, RX_K, IDLE_D, RECEIVE, RX_ERROR, TRI
    } state_t;

    state_t     r_state;
    logic [7:0] r_rxd;
    logic       r_rx_dv;
    logic       r_rx_er;
    logic       r_receiving;
    logic       r_rx_even;
    logic [7:0] r_pkt_count;
    logic       r_pkt_err;

    logic w_comma;
    logic w_sop;
    logic w_eop;
    logic w_cext;

    assign w_comma = rx_is_k && (rx_code_group == K_COMMA);
    assign w_sop   = rx_is_k && (rx_code_group == K_SOP);
    assign w_eop   = rx_is_k && (rx_code_group == K_EOP);
    assign w_cext  = rx_is_k && (rx_code_group == K_CEXT);

    assign RXD       = r_rxd;
    assign RX_DV     = r_rx_dv;
    assign RX_ER     = r_rx_er;
    assign receiving = r_receiving;
    assign rx_even   = r_rx_even;
    assign pkt_count = r_pkt_count;

    always_ff @(posedge GTX_CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= LINK_FAILED;
            r_rxd       <= 8'h00;
            r_rx_dv     <= 1'b0;
            r_rx_er     <= 1'b0;
            r_receiving <= 1'b0;
            r_rx_even   <= 1'b0;
            r_pkt_count <= 8'h00;
            r_pkt_err   <= 1'b0;
        end else begin
            r_rx_even <= w_comma ? 1'b1 : ~r_rx_even;
            // Sync loss overrides every state; an in-flight packet ends with an error cycle.
            if (!sync_status) begin
                r_state     <= LINK_FAILED;
                r_rx_dv     <= 1'b0;
                r_rx_er     <= r_receiving;
                r_receiving <= 1'b0;
            end else begin
                case (r_state)
                    LINK_FAILED: begin
                        r_rx_dv     <= 1'b0;
                        r_rx_er     <= 1'b0;
                        r_receiving <= 1'b0;
                        r_state     <= WAIT_FOR_K;
                    end
                    WAIT_FOR_K: begin
                        r_rx_dv     <= 1'b0;
                        r_rx_er     <= 1'b0;
                        r_receiving <= 1'b0;
                        if (w_comma) r_state <= RX_K;
                    end
                    RX_K: begin
                        r_rx_dv     <= 1'b0;
                        r_rx_er     <= 1'b0;
                        r_receiving <= 1'b0;
                        r_state     <= rx_is_k ? WAIT_FOR_K : IDLE_D;
                    end
                    IDLE_D: begin
                        r_rx_er <= 1'b0;
                        if (w_comma) begin
                            r_rx_dv <= 1'b0;
                            r_state <= RX_K;
                        end else if (w_sop) begin
                            r_rxd       <= PREAMBLE;
                            r_rx_dv     <= 1'b1;
                            r_receiving <= 1'b1;
                            r_pkt_err   <= 1'b0;
                            r_state     <= RECEIVE;
                        end else begin
                            r_rx_dv <= 1'b0;
                            r_state <= WAIT_FOR_K;
                        end
                    end
                    RECEIVE: begin
                        if (!rx_is_k) begin
                            r_rxd   <= rx_code_group;
                            r_rx_dv <= 1'b1;
                            r_rx_er <= 1'b0;
                        end else if (w_eop) begin
                            r_rx_dv <= 1'b0;
                            r_rx_er <= 1'b0;
                            r_state <= TRI;
                        end else begin
                            r_rxd     <= rx_code_group;
                            r_rx_dv   <= 1'b1;
                            r_rx_er   <= 1'b1;
                            r_pkt_err <= 1'b1;
                            r_state   <= RX_ERROR;
                        end
                    end
                    RX_ERROR: begin
                        if (w_eop) begin
                            r_rx_dv <= 1'b0;
                            r_rx_er <= 1'b0;
                            r_state <= TRI;
                        end else if (w_comma) begin
                            r_rx_dv     <= 1'b0;
                            r_rx_er     <= 1'b0;
                            r_receiving <= 1'b0;
                            r_state     <= RX_K;
                        end else begin
                            r_rxd   <= rx_code_group;
                            r_rx_dv <= 1'b1;
                            r_rx_er <= 1'b1;
                        end
                    end
                    TRI: begin
                        r_rx_dv     <= 1'b0;
                        r_receiving <= 1'b0;
                        r_state     <= WAIT_FOR_K;
                        if (w_cext) begin
                            r_rx_er <= 1'b0;
                            if (!r_pkt_err) r_pkt_count <= r_pkt_count + 8'd1;
                        end else begin
                            r_rx_er <= 1'b1;
                        end
                    end
                    default: begin
                        r_rx_dv     <= 1'b0;
                        r_rx_er     <= 1'b0;
                        r_receiving <= 1'b0;
                        r_state     <= LINK_FAILED;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_receptor_pcs.sv
// tb/tb_receptor_pcs.sv - directed self-checking bench for receptor_pcs
module tb_receptor_pcs;
    logic       GTX_CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] rx_code_group = 8'h00;
    logic       rx_is_k = 1'b0;
    logic       sync_status = 1'b0;
    logic [7:0] RXD;
    logic       RX_DV;
    logic       RX_ER;
    logic       receiving;
    logic       rx_even;
    logic [7:0] pkt_count;

    int errors = 0;
    int checks = 0;

    receptor_pcs dut (
        .GTX_CLK(GTX_CLK), .RESET(RESET), .rx_code_group(rx_code_group),
        .rx_is_k(rx_is_k), .sync_status(sync_status), .RXD(RXD), .RX_DV(RX_DV),
        .RX_ER(RX_ER), .receiving(receiving), .rx_even(rx_even), .pkt_count(pkt_count)
    );

    always #5 GTX_CLK = ~GTX_CLK;

    task automatic send(input logic [7:0] cg, input logic k);
        @(negedge GTX_CLK);
        rx_code_group = cg;
        rx_is_k = k;
        @(posedge GTX_CLK);
        #1;
    endtask

    task automatic idle_pair();
        send(8'hBC, 1'b1);
        send(8'h50, 1'b0);
    endtask

    task automatic test_reset();
        #12;
        checks++; if (RXD !== 8'h00) begin errors++; $display("FAIL reset_rxd got=%h exp=00", RXD); end
        checks++; if (RX_DV !== 1'b0) begin errors++; $display("FAIL reset_dv got=%b exp=0", RX_DV); end
        checks++; if (RX_ER !== 1'b0) begin errors++; $display("FAIL reset_er got=%b exp=0", RX_ER); end
        checks++; if (receiving !== 1'b0) begin errors++; $display("FAIL reset_rcv got=%b exp=0", receiving); end
        checks++; if (rx_even !== 1'b0) begin errors++; $display("FAIL reset_even got=%b exp=0", rx_even); end
        checks++; if (pkt_count !== 8'h00) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", pkt_count); end
        @(negedge GTX_CLK);
        RESET = 1'b0;
    endtask

    task automatic test_link_up();
        sync_status = 1'b1;
        send(8'hBC, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send(8'hBC, 1'b1);
            checks++; if (rx_even !== 1'b1) begin errors++; $display("FAIL link_even_comma[%0d] got=%b exp=1", i, rx_even); end
            send(8'h50, 1'b0);
            checks++; if (rx_even !== 1'b0) begin errors++; $display("FAIL link_even_data[%0d] got=%b exp=0", i, rx_even); end
            checks++; if (RX_DV !== 1'b0) begin errors++; $display("FAIL link_dv[%0d] got=%b exp=0", i, RX_DV); end
        end
        checks++; if (pkt_count !== 8'h00) begin errors++; $display("FAIL link_cnt got=%0d exp=0", pkt_count); end
    endtask

    task automatic test_good_packet();
        logic [7:0] exp_d [4];
        exp_d[0] = 8'h55; exp_d[1] = 8'h11; exp_d[2] = 8'h22; exp_d[3] = 8'h33;
        send(8'hFB, 1'b1);
        checks++; if (receiving !== 1'b1) begin errors++; $display("FAIL good_rcv got=%b exp=1", receiving); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) send(exp_d[i], 1'b0);
            checks++; if (RX_DV !== 1'b1 || RX_ER !== 1'b0 || RXD !== exp_d[i])
                begin errors++; $display("FAIL good_beat[%0d] got=dv%b er%b %h exp=dv1 er0 %h", i, RX_DV, RX_ER, RXD, exp_d[i]); end
        end
        send(8'hFD, 1'b1);
        checks++; if (RX_DV !== 1'b0 || receiving !== 1'b1) begin errors++; $display("FAIL good_eop got=dv%b rcv%b exp=dv0 rcv1", RX_DV, receiving); end
        send(8'hF7, 1'b1);
        checks++; if (receiving !== 1'b0 || RX_ER !== 1'b0) begin errors++; $display("FAIL good_end got=rcv%b er%b exp=rcv0 er0", receiving, RX_ER); end
        checks++; if (pkt_count !== 8'd1) begin errors++; $display("FAIL good_cnt got=%0d exp=1", pkt_count); end
        idle_pair();
    endtask

    task automatic test_error_packet();
        send(8'hFB, 1'b1);
        send(8'hAA, 1'b0);
        checks++; if (RXD !== 8'hAA || RX_ER !== 1'b0) begin errors++; $display("FAIL err_data got=%h er%b exp=aa er0", RXD, RX_ER); end
        send(8'hFE, 1'b1);
        checks++; if (RX_ER !== 1'b1 || RX_DV !== 1'b1) begin errors++; $display("FAIL err_v got=er%b dv%b exp=er1 dv1", RX_ER, RX_DV); end
        send(8'hBB, 1'b0);
        checks++; if (RX_ER !== 1'b1 || RX_DV !== 1'b1) begin errors++; $display("FAIL err_hold got=er%b dv%b exp=er1 dv1", RX_ER, RX_DV); end
        send(8'hFD, 1'b1);
        checks++; if (RX_ER !== 1'b0 || RX_DV !== 1'b0) begin errors++; $display("FAIL err_eop got=er%b dv%b exp=er0 dv0", RX_ER, RX_DV); end
        send(8'hF7, 1'b1);
        checks++; if (pkt_count !== 8'd1 || receiving !== 1'b0) begin errors++; $display("FAIL err_cnt got=%0d rcv%b exp=1 rcv0", pkt_count, receiving); end
        idle_pair();
    endtask

    task automatic test_missing_r();
        send(8'hFB, 1'b1);
        send(8'h01, 1'b0);
        send(8'hFD, 1'b1);
        send(8'hBC, 1'b1);
        checks++; if (RX_ER !== 1'b1 || receiving !== 1'b0) begin errors++; $display("FAIL nor_er got=er%b rcv%b exp=er1 rcv0", RX_ER, receiving); end
        checks++; if (pkt_count !== 8'd1) begin errors++; $display("FAIL nor_cnt got=%0d exp=1", pkt_count); end
        send(8'hBC, 1'b1);
        checks++; if (RX_ER !== 1'b0) begin errors++; $display("FAIL nor_er_clear got=%b exp=0", RX_ER); end
        send(8'h50, 1'b0);
    endtask

    task automatic test_sync_loss();
        send(8'hFB, 1'b1);
        send(8'h12, 1'b0);
        checks++; if (RXD !== 8'h12 || RX_DV !== 1'b1) begin errors++; $display("FAIL sync_pre got=%h dv%b exp=12 dv1", RXD, RX_DV); end
        sync_status = 1'b0;
        send(8'h34, 1'b0);
        checks++; if (RX_ER !== 1'b1) begin errors++; $display("FAIL sync_er got=%b exp=1", RX_ER); end
        send(8'h34, 1'b0);
        checks++; if (RX_ER !== 1'b0 || RX_DV !== 1'b0 || receiving !== 1'b0)
            begin errors++; $display("FAIL sync_after got=er%b dv%b rcv%b exp=000", RX_ER, RX_DV, receiving); end
        sync_status = 1'b1;
        send(8'h50, 1'b0);
        send(8'h50, 1'b0);
        send(8'hFB, 1'b1);
        checks++; if (RX_DV !== 1'b0 || receiving !== 1'b0) begin errors++; $display("FAIL sync_nocomma got=dv%b rcv%b exp=dv0 rcv0", RX_DV, receiving); end
        idle_pair();
        send(8'hFB, 1'b1);
        checks++; if (RX_DV !== 1'b1 || RXD !== 8'h55) begin errors++; $display("FAIL sync_relock got=dv%b %h exp=dv1 55", RX_DV, RXD); end
        send(8'hFD, 1'b1);
        send(8'hF7, 1'b1);
        checks++; if (pkt_count !== 8'd2) begin errors++; $display("FAIL sync_cnt got=%0d exp=2", pkt_count); end
        idle_pair();
    endtask

    task automatic test_wrap_and_async_reset();
        for (int i = 0; i < 253; i++) begin
            send(8'hFB, 1'b1); send(8'hFD, 1'b1); send(8'hF7, 1'b1);
            idle_pair();
        end
        checks++; if (pkt_count !== 8'd255) begin errors++; $display("FAIL wrap_255 got=%0d exp=255", pkt_count); end
        send(8'hFB, 1'b1);
        checks++; if (RX_DV !== 1'b1 || RXD !== 8'h55) begin errors++; $display("FAIL min_pkt got=dv%b %h exp=dv1 55", RX_DV, RXD); end
        send(8'hFD, 1'b1);
        checks++; if (RX_DV !== 1'b0) begin errors++; $display("FAIL min_pkt_eop got=%b exp=0", RX_DV); end
        send(8'hF7, 1'b1);
        checks++; if (pkt_count !== 8'd0) begin errors++; $display("FAIL wrap_0 got=%0d exp=0", pkt_count); end
        idle_pair();
        send(8'hFB, 1'b1);
        send(8'h77, 1'b0);
        checks++; if (RX_DV !== 1'b1 || RXD !== 8'h77) begin errors++; $display("FAIL ar_pre got=dv%b %h exp=dv1 77", RX_DV, RXD); end
        #2;
        RESET = 1'b1;
        #1;
        checks++; if (RX_DV !== 1'b0 || RX_ER !== 1'b0 || receiving !== 1'b0)
            begin errors++; $display("FAIL ar_ctrl got=dv%b er%b rcv%b exp=000", RX_DV, RX_ER, receiving); end
        checks++; if (RXD !== 8'h00 || rx_even !== 1'b0 || pkt_count !== 8'h00)
            begin errors++; $display("FAIL ar_data got=%h even%b cnt%0d exp=00 0 0", RXD, rx_even, pkt_count); end
        @(posedge GTX_CLK);
        #1;
        checks++; if (RX_ER !== 1'b0 || RX_DV !== 1'b0) begin errors++; $display("FAIL ar_held got=er%b dv%b exp=er0 dv0", RX_ER, RX_DV); end
        @(negedge GTX_CLK);
        RESET = 1'b0;
    endtask

    initial begin
        test_reset();
        test_link_up();
        test_good_packet();
        test_error_packet();
        test_missing_r();
        test_sync_loss();
        test_wrap_and_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
